// File: rtl/generic_sc_fifo_pkg.sv
// Shared helpers for the single-clock FIFO library: width derivation,
// ratio legality check and the count-update operation encoding.
package generic_sc_fifo_pkg;

   // {write accepted, read accepted}
   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_RD    = 2'b01,
      OP_WR    = 2'b10,
      OP_WR_RD = 2'b11
   } cnt_op_e;

   function automatic bit ratio_ok(input int narrow_w, input int wide_w);
      int ratio;
      if (narrow_w <= 0 || wide_w < narrow_w) return 1'b0;
      if ((wide_w % narrow_w) != 0) return 1'b0;
      ratio = wide_w / narrow_w;
      return ((ratio & (ratio - 1)) == 0);
   endfunction

   function automatic int extend_w(input int narrow_w, input int wide_w);
      return $clog2(wide_w / narrow_w);
   endfunction

   function automatic int narrow_addr_w(input int wide_addr_w, input int narrow_w,
                                        input int wide_w);
      return wide_addr_w + extend_w(narrow_w, wide_w);
   endfunction

endpackage

// File: rtl/generic_sc_packer_fifo_if.sv
// Handshake/status bundle of the narrow-to-wide packer FIFO.
// ovf_o/udf_o exist only when GENERIC_SC_PACKER_FIFO_ERR_EN is defined.
interface generic_sc_packer_fifo_if
   import generic_sc_fifo_pkg::*;
#(
   parameter int RD_ADDR_W = 5,
   parameter int WR_DATA_W = 16,
   parameter int RD_DATA_W = 32
);
   localparam int WR_ADDR_W = narrow_addr_w(RD_ADDR_W, WR_DATA_W, RD_DATA_W);

   logic                 wr_en_i;
   logic [WR_DATA_W-1:0] wr_data_i;
   logic [WR_ADDR_W:0]   wr_usedw_o;
   logic                 wr_empty_o;
   logic                 wr_full_o;
   logic                 rd_en_i;
   logic [RD_DATA_W-1:0] rd_data_o;
   logic [RD_ADDR_W:0]   rd_usedw_o;
   logic                 rd_empty_o;
   logic                 rd_full_o;
`ifdef GENERIC_SC_PACKER_FIFO_ERR_EN
   logic                 ovf_o;
   logic                 udf_o;

   modport slave (
      input  wr_en_i, wr_data_i, rd_en_i,
      output wr_usedw_o, wr_empty_o, wr_full_o,
      output rd_data_o, rd_usedw_o, rd_empty_o, rd_full_o,
      output ovf_o, udf_o
   );
   modport master (
      output wr_en_i, wr_data_i, rd_en_i,
      input  wr_usedw_o, wr_empty_o, wr_full_o,
      input  rd_data_o, rd_usedw_o, rd_empty_o, rd_full_o,
      input  ovf_o, udf_o
   );
`else
   modport slave (
      input  wr_en_i, wr_data_i, rd_en_i,
      output wr_usedw_o, wr_empty_o, wr_full_o,
      output rd_data_o, rd_usedw_o, rd_empty_o, rd_full_o
   );
   modport master (
      output wr_en_i, wr_data_i, rd_en_i,
      input  wr_usedw_o, wr_empty_o, wr_full_o,
      input  rd_data_o, rd_usedw_o, rd_empty_o, rd_full_o
   );
`endif

endinterface

// File: rtl/generic_sc_lane_mem.sv
// Simple dual-port RAM of wide words with per-lane narrow write port and a
// registered wide read port (read register clears on reset, array does not).
module generic_sc_lane_mem #(
   parameter int ADDR_W     = 5,
   parameter int LANE_W     = 16,
   parameter int LANES      = 2,
   parameter int LANE_IDX_W = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wr_en_i,
   input  logic [ADDR_W-1:0]       wr_addr_i,
   input  logic [LANE_IDX_W-1:0]   wr_lane_i,
   input  logic [LANE_W-1:0]       wr_data_i,
   input  logic                    rd_en_i,
   input  logic [ADDR_W-1:0]       rd_addr_i,
   output logic [LANES*LANE_W-1:0] rd_data_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   // One independent array per lane keeps each lane a plain single-write RAM.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem_q [DEPTH];
      logic [LANE_W-1:0] rd_lane_q;

      always_ff @(posedge clk_i) begin
         if (wr_en_i && (wr_lane_i == LANE_IDX_W'(gi))) begin
            mem_q[wr_addr_i] <= wr_data_i;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rd_lane_q <= '0;
         end else if (rd_en_i) begin
            rd_lane_q <= mem_q[rd_addr_i];
         end
      end

      assign rd_data_o[gi*LANE_W +: LANE_W] = rd_lane_q;
   end

endmodule

// File: rtl/generic_sc_packer_fifo.sv
// Single-clock narrow-to-wide packing FIFO, lanes filled LSB first.
// Optional sticky overflow/underflow flags under GENERIC_SC_PACKER_FIFO_ERR_EN.
module generic_sc_packer_fifo
   import generic_sc_fifo_pkg::*;
#(
   parameter int RD_ADDR_W = 5,
   parameter int WR_DATA_W = 16,
   parameter int RD_DATA_W = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   generic_sc_packer_fifo_if.slave bus
);
   localparam int DATA_RATIO = RD_DATA_W / WR_DATA_W;
   localparam int EXTEND_W   = extend_w(WR_DATA_W, RD_DATA_W);
   localparam int WR_ADDR_W  = RD_ADDR_W + EXTEND_W;
   localparam int LANE_IDX_W = (EXTEND_W > 0) ? EXTEND_W : 1;

   localparam logic [WR_ADDR_W:0] WR_FULL_CNT = {1'b1, {WR_ADDR_W{1'b0}}};
   localparam logic [RD_ADDR_W:0] RD_FULL_CNT = {1'b1, {RD_ADDR_W{1'b0}}};
   localparam logic [WR_ADDR_W:0] RATIO_CNT   = (WR_ADDR_W+1)'(DATA_RATIO);

   if (!ratio_ok(WR_DATA_W, RD_DATA_W)) begin : g_ratio_err
      $error("generic_sc_packer_fifo: RD_DATA_W must be a power-of-two multiple of WR_DATA_W");
   end

   logic [WR_ADDR_W:0]    cnt_q, cnt_d;
   logic [WR_ADDR_W-1:0]  wr_ptr_q;
   logic [RD_ADDR_W-1:0]  rd_ptr_q;
   logic [RD_ADDR_W:0]    rd_usedw;
   logic                  wr_full, rd_empty;
   logic                  wr_accept, rd_accept;
   logic [RD_ADDR_W-1:0]  wr_entry;
   logic [LANE_IDX_W-1:0] wr_lane;
   cnt_op_e               cnt_op;

   assign rd_usedw  = (RD_ADDR_W+1)'(cnt_q >> EXTEND_W);
   assign wr_full   = (cnt_q == WR_FULL_CNT);
   assign rd_empty  = (rd_usedw == '0);
   assign wr_accept = bus.wr_en_i && !wr_full;
   assign rd_accept = bus.rd_en_i && !rd_empty;
   assign cnt_op    = cnt_op_e'({wr_accept, rd_accept});

   if (EXTEND_W > 0) begin : g_split_ptr
      assign wr_entry = wr_ptr_q[WR_ADDR_W-1:EXTEND_W];
      assign wr_lane  = wr_ptr_q[EXTEND_W-1:0];
   end else begin : g_flat_ptr
      assign wr_entry = wr_ptr_q;
      assign wr_lane  = '0;
   end

   always_comb begin
      cnt_d = cnt_q;
      case (cnt_op)
         OP_WR:    cnt_d = cnt_q + 1'b1;
         OP_RD:    cnt_d = cnt_q - RATIO_CNT;
         OP_WR_RD: cnt_d = cnt_q + 1'b1 - RATIO_CNT;
         default:  cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_accept) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   generic_sc_lane_mem #(
      .ADDR_W     (RD_ADDR_W),
      .LANE_W     (WR_DATA_W),
      .LANES      (DATA_RATIO),
      .LANE_IDX_W (LANE_IDX_W)
   ) u_mem (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_accept),
      .wr_addr_i (wr_entry),
      .wr_lane_i (wr_lane),
      .wr_data_i (bus.wr_data_i),
      .rd_en_i   (rd_accept),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (bus.rd_data_o)
   );

   assign bus.wr_usedw_o = cnt_q;
   assign bus.wr_empty_o = (cnt_q == '0);
   assign bus.wr_full_o  = wr_full;
   assign bus.rd_usedw_o = rd_usedw;
   assign bus.rd_empty_o = rd_empty;
   assign bus.rd_full_o  = (rd_usedw == RD_FULL_CNT);

`ifdef GENERIC_SC_PACKER_FIFO_ERR_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (bus.wr_en_i && wr_full)  ovf_q <= 1'b1;
         if (bus.rd_en_i && rd_empty) udf_q <= 1'b1;
      end
   end

   assign bus.ovf_o = ovf_q;
   assign bus.udf_o = udf_q;
`endif

endmodule

// File: tb/tb_generic_sc_packer_fifo.sv
// Self-checking bench for generic_sc_packer_fifo: vector table, directed
// corner sequences and random traffic against a queue-based reference.
module tb_generic_sc_packer_fifo;
   import generic_sc_fifo_pkg::*;

   localparam int DEPTH_N = 64;
   localparam int RATIO   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   generic_sc_packer_fifo_if #(.RD_ADDR_W(5), .WR_DATA_W(16), .RD_DATA_W(32)) bus ();

   generic_sc_packer_fifo #(.RD_ADDR_W(5), .WR_DATA_W(16), .RD_DATA_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference: a queue of stored narrow words; a wide read pops RATIO of them.
   logic [15:0] mq[$];
   logic [31:0] m_rd;
   bit          m_ovf, m_udf;

   typedef struct {
      logic        we;
      logic [15:0] wd;
      logic        re;
      int          exp_wu;
      int          exp_ru;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic we, input logic [15:0] wd, input logic re, input logic rs);
      bit wacc, racc;
      logic [15:0] lo, hi;
      wacc = we && (mq.size() < DEPTH_N);
      racc = re && (mq.size() >= RATIO);
      bus.wr_en_i   = we;
      bus.wr_data_i = wd;
      bus.rd_en_i   = re;
      rst           = rs;
      @(posedge clk);
      #1;
      bus.wr_en_i = 1'b0;
      bus.rd_en_i = 1'b0;
      rst         = 1'b0;
      if (rs) begin
         mq.delete();
         m_rd  = '0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (we && mq.size() == DEPTH_N) m_ovf = 1'b1;
         if (re && mq.size() < RATIO)    m_udf = 1'b1;
         if (racc) begin
            lo   = mq.pop_front();
            hi   = mq.pop_front();
            m_rd = {hi, lo};
         end
         if (wacc) mq.push_back(wd);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".wr_usedw"}, 64'(bus.wr_usedw_o), 64'(mq.size()));
      chk({tag, ".rd_usedw"}, 64'(bus.rd_usedw_o), 64'(mq.size() / RATIO));
      chk({tag, ".wr_empty"}, 64'(bus.wr_empty_o), 64'(mq.size() == 0));
      chk({tag, ".wr_full"},  64'(bus.wr_full_o),  64'(mq.size() == DEPTH_N));
      chk({tag, ".rd_empty"}, 64'(bus.rd_empty_o), 64'(mq.size() < RATIO));
      chk({tag, ".rd_full"},  64'(bus.rd_full_o),  64'(mq.size() / RATIO == DEPTH_N / RATIO));
      chk({tag, ".rd_data"},  64'(bus.rd_data_o),  64'(m_rd));
`ifdef GENERIC_SC_PACKER_FIFO_ERR_EN
      chk({tag, ".ovf"}, 64'(bus.ovf_o), 64'(m_ovf));
      chk({tag, ".udf"}, 64'(bus.udf_o), 64'(m_udf));
`endif
   endtask

   logic [15:0] words[DEPTH_N];
   int          n_rand_ops;

   initial begin
      bus.wr_en_i   = 1'b0;
      bus.wr_data_i = '0;
      bus.rd_en_i   = 1'b0;
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;

      vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1, 0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 16'h2222, 1'b0, 2, 1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 16'h0000, 1'b1, 0, 0, 32'h2222_1111};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 0, 0, 32'h2222_1111};
      vecs[4]  = '{1'b1, 16'hAAAA, 1'b0, 1, 0, 32'h2222_1111};
      vecs[5]  = '{1'b1, 16'hBBBB, 1'b0, 2, 1, 32'h2222_1111};
      vecs[6]  = '{1'b1, 16'hCCCC, 1'b0, 3, 1, 32'h2222_1111};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1, 0, 32'hBBBB_AAAA};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1, 0, 32'hBBBB_AAAA};
      vecs[9]  = '{1'b1, 16'hDDDD, 1'b0, 2, 1, 32'hBBBB_AAAA};
      vecs[10] = '{1'b1, 16'hEEEE, 1'b1, 1, 0, 32'hDDDD_CCCC};

      // Reset and idle
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      cycle(1'b0, 16'h0, 1'b0, 1'b0);
      chk("reset.wr_empty", 64'(bus.wr_empty_o), 64'd1);
      chk("reset.rd_empty", 64'(bus.rd_empty_o), 64'd1);
      chk("reset.wr_usedw", 64'(bus.wr_usedw_o), 64'd0);
      chk("reset.rd_data",  64'(bus.rd_data_o),  64'd0);
      check_model("reset");

      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].we, vecs[i].wd, vecs[i].re, 1'b0);
         chk($sformatf("vec%0d.wr_usedw", i), 64'(bus.wr_usedw_o), 64'(vecs[i].exp_wu));
         chk($sformatf("vec%0d.rd_usedw", i), 64'(bus.rd_usedw_o), 64'(vecs[i].exp_ru));
         chk($sformatf("vec%0d.rd_data", i),  64'(bus.rd_data_o),  64'(vecs[i].exp_rd));
         check_model($sformatf("vec%0d", i));
      end

      // Fill to full, overflow attempt, drain in order
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH_N; i++) begin
         words[i] = 16'($urandom);
         cycle(1'b1, words[i], 1'b0, 1'b0);
      end
      chk("full.wr_full",  64'(bus.wr_full_o),  64'd1);
      chk("full.rd_full",  64'(bus.rd_full_o),  64'd1);
      chk("full.wr_usedw", 64'(bus.wr_usedw_o), 64'd64);
      chk("full.rd_usedw", 64'(bus.rd_usedw_o), 64'd32);
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
      chk("ovf.wr_usedw", 64'(bus.wr_usedw_o), 64'd64);
`ifdef GENERIC_SC_PACKER_FIFO_ERR_EN
      chk("ovf.flag", 64'(bus.ovf_o), 64'd1);
`endif
      check_model("ovf");
      for (int i = 0; i < DEPTH_N / RATIO; i++) begin
         cycle(1'b0, 16'h0, 1'b1, 1'b0);
         chk($sformatf("drain%0d.rd_data", i), 64'(bus.rd_data_o),
             64'({words[2*i+1], words[2*i]}));
      end
      check_model("drained");

      // Simultaneous write and read at wr_usedw=4
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      cycle(1'b1, 16'h0010, 1'b0, 1'b0);
      cycle(1'b1, 16'h0020, 1'b0, 1'b0);
      cycle(1'b1, 16'h0030, 1'b0, 1'b0);
      cycle(1'b1, 16'h0040, 1'b0, 1'b0);
      chk("rw.pre_usedw", 64'(bus.wr_usedw_o), 64'd4);
      cycle(1'b1, 16'h0050, 1'b1, 1'b0);
      chk("rw.wr_usedw", 64'(bus.wr_usedw_o), 64'd3);
      chk("rw.rd_usedw", 64'(bus.rd_usedw_o), 64'd1);
      chk("rw.rd_data0", 64'(bus.rd_data_o),  64'h0020_0010);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      chk("rw.rd_data1", 64'(bus.rd_data_o),  64'h0040_0030);
      cycle(1'b1, 16'h0060, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      chk("rw.rd_data2", 64'(bus.rd_data_o),  64'h0060_0050);
      check_model("rw");

      // Reset in the middle with a partial word held
      for (int i = 0; i < 37; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
      chk("mid.wr_usedw", 64'(bus.wr_usedw_o), 64'd37);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      chk("mid_rst.wr_usedw", 64'(bus.wr_usedw_o), 64'd0);
      chk("mid_rst.rd_usedw", 64'(bus.rd_usedw_o), 64'd0);
      chk("mid_rst.wr_empty", 64'(bus.wr_empty_o), 64'd1);
      chk("mid_rst.rd_empty", 64'(bus.rd_empty_o), 64'd1);
      chk("mid_rst.wr_full",  64'(bus.wr_full_o),  64'd0);
      chk("mid_rst.rd_data",  64'(bus.rd_data_o),  64'd0);
      cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
      cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      chk("mid_rst.readback", 64'(bus.rd_data_o), 64'h5A5A_A5A5);
      check_model("mid_rst");

      // Random traffic with phase-varying write/read bias and rare resets
      n_rand_ops = 3000;
      for (int i = 0; i < n_rand_ops; i++) begin
         int wr_pct, rd_pct;
         wr_pct = ((i / 200) % 2 == 0) ? 80 : 35;
         rd_pct = ((i / 200) % 2 == 0) ? 30 : 75;
         cycle($urandom_range(99) < wr_pct, 16'($urandom), $urandom_range(99) < rd_pct,
               $urandom_range(499) == 0);
         check_model($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
